// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision sequential adder.
package mp_add_pkg;
  localparam int LIMB_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle between the sequential adder and its neighbours.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int NBYTES = 4
);
  localparam int W = LIMB_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/mp_add_seq.sv
// Sequential W-bit adder: walks one byte limb per cycle through an external
// 8-bit ripple-carry adder, LSB first, and presents the registered result.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mp_add_seq_if.slave        bus,
  output logic [LIMB_W-1:0]  add_x,
  output logic [LIMB_W-1:0]  add_y,
  output logic               add_ci,
  input  logic [LIMB_W-1:0]  add_s,
  input  logic               add_co
);
  localparam int W     = LIMB_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    add_x       = '0;
    add_y       = '0;
    add_ci      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_a_d     = bus.a;
          op_b_d     = bus.b;
          carry_d    = bus.cin;
          sum_d      = '0;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        add_x   = op_a_q[LIMB_W*int'(idx_q) +: LIMB_W];
        add_y   = op_b_q[LIMB_W*int'(idx_q) +: LIMB_W];
        add_ci  = carry_q;
        sum_d[LIMB_W*int'(idx_q) +: LIMB_W] = add_s;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: like-signed operands yielding an opposite-signed MSB limb.
          cout_d      = add_co;
          ovf_d       = (op_a_q[W-1] == op_b_q[W-1]) && (add_s[LIMB_W-1] != op_a_q[W-1]);
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq with NBYTES=4 and a behavioural 8-bit adder on add_*.
module tb_mp_add_seq;
  localparam int NB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] add_x, add_y, add_s;
  logic       add_ci, add_co;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mp_add_seq_if #(.NBYTES(NB)) bus ();

  mp_add_seq #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .add_x  (add_x),
    .add_y  (add_y),
    .add_ci (add_ci),
    .add_s  (add_s),
    .add_co (add_co)
  );

  // External 8-bit ripple-carry adder.
  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'b0, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: whole-word arithmetic straight from the add/overflow definitions.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                output logic [31:0] s, output logic co, output logic ov);
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    s    = full[31:0];
    co   = full[32];
    ov   = (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Issue one request, wait for out_valid; returns cycles from accept edge.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                output int lat);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.out_valid) begin
        lat = i - 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!bus.out_valid) begin
      errors++;
      checks++;
      $display("FAIL timeout: out_valid never rose for a=0x%0h b=0x%0h", a, b);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[5];
  int lat;
  logic [31:0] ms, hold_sum;
  logic mc, mo, hold_cout, hold_ovf;

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
    chk("rst_add_bus", 64'({add_x, add_y, add_ci}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors 0..3
    for (int i = 0; i < 4; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NB));
      chk($sformatf("vec%0d_sum", i), 64'(bus.sum), 64'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(bus.cout), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_in_ready_done", i), 64'(bus.in_ready), 64'd0);
      ack();
      chk($sformatf("vec%0d_in_ready_after", i), 64'(bus.in_ready), 64'd1);
      chk($sformatf("vec%0d_sum_kept", i), 64'(bus.sum), 64'(vecs[i].sum));
    end

    // Backpressure in DONE with a stray request
    start_and_wait(32'h00000001, 32'h00000002, 1'b0, lat);
    hold_sum = bus.sum; hold_cout = bus.cout; hold_ovf = bus.ovf;
    chk("bp_sum", 64'(hold_sum), 64'd3);
    @(negedge clk);
    bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.cin = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum_stable", 64'(bus.sum), 64'(hold_sum));
      chk("bp_flags_stable", 64'({bus.cout, bus.ovf}), 64'({hold_cout, hold_ovf}));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra_accept", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("bp_sum_after", 64'(bus.sum), 64'd3);

    // Reset during the 2nd RUN cycle
    @(negedge clk);
    bus.a = 32'h0F0F0F0F; bus.b = 32'h01010101; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.sum), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    start_and_wait(vecs[4].a, vecs[4].b, vecs[4].cin, lat);
    chk("post_rst_sum", 64'(bus.sum), 64'(vecs[4].sum));
    chk("post_rst_flags", 64'({bus.cout, bus.ovf}), 64'({vecs[4].cout, vecs[4].ovf}));
    ack();

    // Back-to-back random traffic against the reference model
    begin
      logic [31:0] qa[$], qb[$];
      logic        qc[$];
      logic [31:0] ra, rb, ea, eb;
      logic        rc, ec;
      int acc, got, last_res;
      acc = 0; got = 0; last_res = -1;
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int t = 0; t < 200 && got < 10; t++) begin
        if (bus.out_valid) begin
          ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
          model(ea, eb, ec, ms, mc, mo);
          chk("b2b_sum", 64'(bus.sum), 64'(ms));
          chk("b2b_flags", 64'({bus.cout, bus.ovf}), 64'({mc, mo}));
          if (last_res >= 0) chk("b2b_period", 64'(cyc - last_res), 64'(NB + 2));
          last_res = cyc;
          got++;
        end
        if (bus.in_ready || bus.out_valid)
          chk("b2b_adder_idle", 64'({add_x, add_y, add_ci}), 64'd0);
        if (bus.in_ready) begin
          if (acc < 10) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1, 0));
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            qa.push_back(ra); qb.push_back(rb); qc.push_back(rc);
            acc++;
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_result_count", 64'(got), 64'd10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
